hex_scroll_ctrl: RTL and testbench
==================================

// Module: hex_scroll_ctrl
// PURPOSE
//  Sequencer for the eight 7-segment displays HEX7..HEX0 (HEX7 leftmost).
//  Accepts a message of up to MSG_DEPTH character codes over a valid/ready
//  write port and buffers it. Shows the message statically, or scrolls it
//  left at a rate derived from the board's 500 Hz tick. Sits in usertop
//  between user logic and the HEX outputs.
// PARAMETERS
//  MSG_DEPTH   16   buffer depth in characters; power of 2, 8..64
//  SCROLL_DIV  250  500 Hz ticks per scroll step (250 -> 2 steps/s); >=1
// PORTS
//  CLOCK_50   in   1   system clock, 50 MHz; all state on rising edge
//  RESET_N    in   1   asynchronous, active-low reset
//  CLK_500Hz  in   1   500 Hz square wave; used as data, never as a clock
//  wr_valid   in   1   wr_char valid
//  wr_ready   out  1   controller accepts a char this cycle
//  wr_char    in   5   char code: 0-15 hex digit, 16 blank, 17 '-', 18 H, 19 L, 20 P, other blank
//  wr_last    in   1   qualifies the final char of a message
//  scroll     in   1   1 = scroll when length > 8; 0 = static window
//  run        in   1   0 freezes the scroll position
//  blink      in   1   blink request; used only with HEX_BLINK_EN
//  busy       out  1   a load is in progress
//  overflow   out  1   sticky: a char arrived while the buffer was full
//  HEX0..HEX7 out  8   segments, active-low; [6:0]=g..a, [7]=dp, always 1
// BEHAVIOUR
//  - Reset: state IDLE; len=0, ptr=0, tick_cnt=0; busy=0, overflow=0, wr_ready=1.
//    All HEX = 8'hFF (blank). Reset mid-load discards the partial message.
//  - Tick: CLK_500Hz passes through a 2-flop synchroniser, then a rising-edge
//    detect gives a 1-cycle tick pulse. tick_cnt counts ticks 0..SCROLL_DIV-1.
//    When it wraps, a step pulse fires.
//  - FSM: IDLE -> LOAD on the first accepted char.
//    In LOAD, each accepted char is written at wr_ptr, then wr_ptr is incremented.
//    An accepted char with wr_last -> SHOW, with len=wr_ptr+1 (saturating at MSG_DEPTH).
//    SHOW -> LOAD on an accepted char; wr_ptr is reset, ptr is reset, and the
//    old frame holds until wr_last.
//  - wr_ready is 1 in every state; a transfer occurs when wr_valid&wr_ready.
//    When wr_ptr==MSG_DEPTH, chars are dropped and overflow is set.
//    wr_last still completes the load.
//  - busy=1 exactly while in LOAD.
//  - Display: digit k (HEX7 is k=0) shows buf[(ptr+k) mod len] when scrolling.
//    Otherwise it shows buf[k] for k<len and blank for k>=len. len=0 gives all blank.
//  - Scrolling is active only when scroll=1, run=1, state SHOW and len>8.
//    Each step then does ptr <= (ptr==len-1) ? 0 : ptr+1.
//    scroll=0 forces ptr to 0 on the next cycle.
//  - HEX outputs are registered: 1 cycle of latency from a buffer/ptr change.
//    The final char is visible on the cycle after wr_last is accepted + 1.
//  - Simultaneous events: a load accept in SHOW takes priority over a step.
//    A step arriving in the same cycle is discarded.
// CONFIGURATION
//  HEX_BLINK_EN defined: with blink=1 in SHOW, all digits toggle between the
//    frame and blank every 125 ticks (2 Hz), starting from the visible phase.
//    Deasserting blink restores the frame on the next cycle.
//    Scroll timing is unaffected.
//  HEX_BLINK_EN undefined: blink is ignored, no blink counter is built, and
//    the behaviour is identical to blink=0.
// STRUCTURE
//  hex_scroll_pkg holds:
//  - state enum {IDLE, LOAD, SHOW};
//  - char-code localparams (CH_BLANK=16, CH_DASH=17, CH_H=18, CH_L=19, CH_P=20);
//  - SEG_BLANK=7'h7F.
//  Sub-module seg7_encode: combinational 5-bit code -> 7-bit active-low pattern,
//  instantiated once per digit.
//  Codes 0..F use the standard patterns: 0=7'b1000000, 1=7'b1111001, 5=7'b0010010.
// TESTING
//  1. Reset -> all HEX=8'hFF, busy=0, overflow=0, wr_ready=1.
//  2. Load 5,0,1,5 (last on 5), scroll=0 -> HEX7..HEX4 = 0010010,1000000,1111001,0010010;
//     HEX3..0 blank.
//  3. Load 12 chars 0..B, scroll=1, run=1, SCROLL_DIV=2 -> HEX7 shows 1 after 2 ticks.
//     After 12 steps HEX7 shows 0 (wrap), and HEX0 shows buf[(ptr+7)mod 12].
//  4. Write 20 chars with MSG_DEPTH=16 -> overflow=1, len=16, chars 16..19 dropped;
//     a new load keeps overflow=1 until reset.
//  5. Mid-scroll: run=0 freezes the frame; a new load in SHOW holds the old frame,
//     then shows the new message from ptr 0. Assert RESET_N low mid-load ->
//     all blank immediately.
//  6. HEX_BLINK_EN, blink=1 -> frame visible for 125 ticks, then blank for 125
//     ticks; the same test without the macro shows a steady frame.

Source files
------------

// File: rtl/hex_scroll_pkg.sv
// Shared types and constants for the HEX display sequencer: FSM states, character codes, blank pattern.
// No logic or latency of its own.
package hex_scroll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2
    } state_t;

    localparam logic [4:0] CH_BLANK = 5'd16;
    localparam logic [4:0] CH_DASH  = 5'd17;
    localparam logic [4:0] CH_H     = 5'd18;
    localparam logic [4:0] CH_L     = 5'd19;
    localparam logic [4:0] CH_P     = 5'd20;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // 125 ticks of the 500 Hz reference per blink phase gives a 2 Hz blink.
    localparam int BLINK_TICKS = 125;

endpackage

// File: rtl/seg7_encode.sv
// Character code to active-low g..a segment pattern; purely combinational, zero latency, no handshake.
// Codes 0-15 are hex digits; 16 and anything above 20 are blank.
module seg7_encode
    import hex_scroll_pkg::*;
(
    input  logic [4:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            5'd0:    o_seg = 7'b1000000;
            5'd1:    o_seg = 7'b1111001;
            5'd2:    o_seg = 7'b0100100;
            5'd3:    o_seg = 7'b0110000;
            5'd4:    o_seg = 7'b0011001;
            5'd5:    o_seg = 7'b0010010;
            5'd6:    o_seg = 7'b0000010;
            5'd7:    o_seg = 7'b1111000;
            5'd8:    o_seg = 7'b0000000;
            5'd9:    o_seg = 7'b0010000;
            5'd10:   o_seg = 7'b0001000;
            5'd11:   o_seg = 7'b0000011;
            5'd12:   o_seg = 7'b1000110;
            5'd13:   o_seg = 7'b0100001;
            5'd14:   o_seg = 7'b0000110;
            5'd15:   o_seg = 7'b0001110;
            CH_DASH: o_seg = 7'b0111111;
            CH_H:    o_seg = 7'b0001001;
            CH_L:    o_seg = 7'b1000111;
            CH_P:    o_seg = 7'b0001100;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Buffers a character message and drives HEX7..HEX0 statically or scrolling left; HEX_BLINK_EN adds a 2 Hz blink.
// HEX is registered (1 cycle after a buffer/ptr change); wr_ready is always 1, chars beyond MSG_DEPTH are dropped and flag overflow.
module hex_scroll_ctrl
    import hex_scroll_pkg::*;
#(
    parameter int MSG_DEPTH  = 16,
    parameter int SCROLL_DIV = 250
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       CLK_500Hz,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [4:0] wr_char,
    input  logic       wr_last,
    input  logic       scroll,
    input  logic       run,
    input  logic       blink,
    output logic       busy,
    output logic       overflow,
    output logic [7:0] HEX0,
    output logic [7:0] HEX1,
    output logic [7:0] HEX2,
    output logic [7:0] HEX3,
    output logic [7:0] HEX4,
    output logic [7:0] HEX5,
    output logic [7:0] HEX6,
    output logic [7:0] HEX7
);

    localparam int          AW      = $clog2(MSG_DEPTH);
    localparam int          TW      = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(MSG_DEPTH);

    state_t          r_state;
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_len;
    logic [AW-1:0]   r_ptr;
    logic            r_ovf;
    logic [2:0]      r_sync;
    logic [TW-1:0]   r_tick_cnt;
    logic [4:0]      r_buf [MSG_DEPTH];
    logic [6:0]      r_seg [8];

    logic            w_accept;
    logic            w_full;
    logic            w_tick;
    logic            w_step;
    logic            w_scroll_mode;
    logic            w_scroll_act;
    logic            w_blank_phase;
    logic [AW:0]     w_wr_idx;
    logic [6:0]      w_seg [8];

    assign wr_ready = 1'b1;
    assign busy     = (r_state == LOAD);
    assign overflow = r_ovf;

    assign w_accept = wr_valid & wr_ready;
    // Any accept outside LOAD starts a fresh message at slot 0.
    assign w_wr_idx = (r_state == LOAD) ? r_wr_ptr : '0;
    assign w_full   = (w_wr_idx == DEPTH_L);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync     <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_sync <= {r_sync[1:0], CLK_500Hz};
            if (w_tick) begin
                r_tick_cnt <= w_step ? '0 : r_tick_cnt + 1'b1;
            end
        end
    end

    assign w_tick        = r_sync[1] & ~r_sync[2];
    assign w_step        = w_tick && (r_tick_cnt == TW'(SCROLL_DIV - 1));
    assign w_scroll_mode = scroll && (r_len > (AW+1)'(8));
    assign w_scroll_act  = w_scroll_mode && run && (r_state == SHOW) && w_step;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= IDLE;
            r_wr_ptr <= '0;
            r_len    <= '0;
            r_ptr    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_accept) begin
                // A load accept wins over a coincident scroll step.
                r_ptr <= '0;
                if (w_full) begin
                    r_ovf <= 1'b1;
                end
                if (wr_last) begin
                    r_state  <= SHOW;
                    r_wr_ptr <= '0;
                    r_len    <= w_full ? DEPTH_L : w_wr_idx + 1'b1;
                end else begin
                    r_state  <= LOAD;
                    r_wr_ptr <= w_full ? w_wr_idx : w_wr_idx + 1'b1;
                end
            end else if (!scroll) begin
                r_ptr <= '0;
            end else if (w_scroll_act) begin
                r_ptr <= ({1'b0, r_ptr} == r_len - 1'b1) ? '0 : r_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_accept && !w_full) begin
            r_buf[w_wr_idx[AW-1:0]] <= wr_char;
        end
    end

    for (genvar k = 0; k < 8; k++) begin : g_digit
        logic [AW:0] w_sum;
        logic [AW:0] w_idx;
        logic [4:0]  w_code;

        // ptr < len and k < 8 < len, so one conditional subtract is the modulo.
        assign w_sum = {1'b0, r_ptr} + (AW+1)'(k);
        assign w_idx = (w_sum >= r_len) ? w_sum - r_len : w_sum;

        always_comb begin
            w_code = CH_BLANK;
            if (w_scroll_mode) begin
                w_code = r_buf[w_idx[AW-1:0]];
            end else if ((AW+1)'(k) < r_len) begin
                w_code = r_buf[k];
            end
        end

        seg7_encode u_enc (
            .i_code (w_code),
            .o_seg  (w_seg[k])
        );
    end

`ifdef HEX_BLINK_EN
    logic [6:0] r_blink_cnt;
    logic       r_blink_off;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (!(blink && r_state == SHOW)) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (w_tick) begin
            if (r_blink_cnt == 7'(BLINK_TICKS - 1)) begin
                r_blink_cnt <= '0;
                r_blink_off <= ~r_blink_off;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_blank_phase = r_blink_off;
`else
    assign w_blank_phase = blink & 1'b0;
`endif

    // The frame is frozen during LOAD so the old message stays up until wr_last.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int k = 0; k < 8; k++) begin
                r_seg[k] <= SEG_BLANK;
            end
        end else if (r_state != LOAD) begin
            for (int k = 0; k < 8; k++) begin
                r_seg[k] <= w_blank_phase ? SEG_BLANK : w_seg[k];
            end
        end
    end

    assign HEX7 = {1'b1, r_seg[0]};
    assign HEX6 = {1'b1, r_seg[1]};
    assign HEX5 = {1'b1, r_seg[2]};
    assign HEX4 = {1'b1, r_seg[3]};
    assign HEX3 = {1'b1, r_seg[4]};
    assign HEX2 = {1'b1, r_seg[5]};
    assign HEX1 = {1'b1, r_seg[6]};
    assign HEX0 = {1'b1, r_seg[7]};

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed plus randomized bench for hex_scroll_ctrl against a message/pointer reference model.
module tb_hex_scroll_ctrl;

    localparam int DEPTH = 16;
    localparam int DIV   = 2;

    logic       CLOCK_50  = 1'b0;
    logic       RESET_N   = 1'b1;
    logic       CLK_500Hz = 1'b0;
    logic       wr_valid  = 1'b0;
    logic [4:0] wr_char   = 5'd0;
    logic       wr_last   = 1'b0;
    logic       scroll    = 1'b0;
    logic       run       = 1'b0;
    logic       blink     = 1'b0;
    logic       wr_ready;
    logic       busy;
    logic       overflow;
    logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

    int vectors     = 0;
    int miscompares = 0;

    int m_buf [DEPTH];
    int m_len   = 0;
    int m_ptr   = 0;
    int m_ticks = 0;
    bit m_ovf   = 1'b0;
    int msg [32];

    always #10 CLOCK_50 = ~CLOCK_50;

    hex_scroll_ctrl #(
        .MSG_DEPTH  (DEPTH),
        .SCROLL_DIV (DIV)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .CLK_500Hz (CLK_500Hz),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_char   (wr_char),
        .wr_last   (wr_last),
        .scroll    (scroll),
        .run       (run),
        .blink     (blink),
        .busy      (busy),
        .overflow  (overflow),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3),
        .HEX4      (HEX4),
        .HEX5      (HEX5),
        .HEX6      (HEX6),
        .HEX7      (HEX7)
    );

    task automatic cyc();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_ref(input int c);
        case (c)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            15: return 7'b0001110;
            17: return 7'b0111111;
            18: return 7'b0001001;
            19: return 7'b1000111;
            20: return 7'b0001100;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected content of display position k (0 = HEX7) from the message model.
    function automatic logic [7:0] exp_digit(input int k);
        int c;
        if (m_len == 0) return 8'hFF;
        if (scroll && m_len > 8) c = m_buf[(m_ptr + k) % m_len];
        else if (k < m_len)      c = m_buf[k];
        else                     return 8'hFF;
        return {1'b1, seg_ref(c)};
    endfunction

    function automatic logic [7:0] get_hex(input int k);
        case (k)
            0: return HEX7;
            1: return HEX6;
            2: return HEX5;
            3: return HEX4;
            4: return HEX3;
            5: return HEX2;
            6: return HEX1;
            default: return HEX0;
        endcase
    endfunction

    task automatic chk_frame(input string tag);
        for (int k = 0; k < 8; k++) chk($sformatf("%s_d%0d", tag, k), get_hex(k), exp_digit(k));
    endtask

    task automatic chk_blank(input string tag);
        for (int k = 0; k < 8; k++) chk($sformatf("%s_d%0d", tag, k), get_hex(k), 8'hFF);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        #1;
        m_len = 0; m_ptr = 0; m_ticks = 0; m_ovf = 1'b0;
        chk_blank("rst_hex");
        chk("rst_busy",  {7'b0, busy},     8'h00);
        chk("rst_ovf",   {7'b0, overflow}, 8'h00);
        chk("rst_ready", {7'b0, wr_ready}, 8'h01);
        wr_valid = 1'b0; wr_last = 1'b0; CLK_500Hz = 1'b0;
        repeat (2) cyc();
        RESET_N = 1'b1;
        cyc();
    endtask

    // Sends msg[0..n-1]; checks busy, that the old frame holds, and the one-cycle reveal.
    task automatic load_msg(input int n, input bit gaps, input bit chk_hold);
        logic [7:0] old7;
        int sent;
        old7 = exp_digit(0);
        sent = 0;
        while (sent < n) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                wr_valid = 1'b0; wr_last = 1'b0;
                cyc();
            end else begin
                wr_valid = 1'b1;
                wr_char  = msg[sent][4:0];
                wr_last  = (sent == n - 1);
                cyc();
                sent++;
                if (sent < n) begin
                    chk("busy_load", {7'b0, busy}, 8'h01);
                    if (chk_hold) chk("hold_old", HEX7, old7);
                end
            end
        end
        wr_valid = 1'b0; wr_last = 1'b0;
        chk("busy_done", {7'b0, busy}, 8'h00);
        if (chk_hold) chk("reveal_lat", HEX7, old7);
        m_len = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < m_len; i++) m_buf[i] = msg[i];
        m_ptr = 0;
        if (n > DEPTH) m_ovf = 1'b1;
        cyc();
        chk_frame("frame");
    endtask

    // One full 500 Hz period; the model advances ptr on every DIV-th tick since reset.
    task automatic tick();
        CLK_500Hz = 1'b1;
        repeat (4) cyc();
        CLK_500Hz = 1'b0;
        repeat (4) cyc();
        if (scroll && run && m_len > 8 && (m_ticks % DIV == DIV - 1)) m_ptr = (m_ptr + 1) % m_len;
        m_ticks++;
    endtask

    task automatic set_scroll(input logic s);
        scroll = s;
        if (!s) m_ptr = 0;
        repeat (2) cyc();
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int nt;
        #5;
        do_reset();

        // Static four-digit message.
        scroll = 1'b0; run = 1'b0;
        msg[0] = 5; msg[1] = 0; msg[2] = 1; msg[3] = 5;
        load_msg(4, 1'b0, 1'b1);
        chk("t2_hex7", HEX7, 8'h92);
        chk("t2_hex6", HEX6, 8'hC0);
        chk("t2_hex5", HEX5, 8'hF9);
        chk("t2_hex4", HEX4, 8'h92);
        chk("t2_hex3", HEX3, 8'hFF);

        // Twelve-char scroll: one step per two ticks, wraps after twelve steps.
        set_scroll(1'b1); run = 1'b1;
        for (int i = 0; i < 12; i++) msg[i] = i;
        load_msg(12, 1'b1, 1'b1);
        repeat (2) tick();
        chk("t3_step1", HEX7, 8'hF9);
        chk_frame("t3_f1");
        for (int i = 0; i < 22; i++) begin
            tick();
            chk_frame("t3_scroll");
        end
        chk("t3_wrap", HEX7, 8'hC0);

        // Freeze with run=0, reload in SHOW, then scroll=0 returns to ptr 0.
        repeat (3) tick();
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_frame("t5_frozen");
        end
        run = 1'b1;
        for (int i = 0; i < 10; i++) msg[i] = $urandom_range(0, 20);
        load_msg(10, 1'b1, 1'b1);
        repeat (5) tick();
        chk_frame("t5_new");
        set_scroll(1'b0);
        chk_frame("t5_static");

        // Overflow: 20 chars into 16 slots, sticky across a following load.
        set_scroll(1'b1);
        for (int i = 0; i < 20; i++) msg[i] = i;
        load_msg(20, 1'b1, 1'b1);
        chk("t4_ovf", {7'b0, overflow}, 8'h01);
        repeat (6) tick();
        chk_frame("t4_scroll");
        for (int i = 0; i < 5; i++) msg[i] = 15 - i;
        load_msg(5, 1'b0, 1'b1);
        chk("t4_ovf_sticky", {7'b0, overflow}, 8'h01);

        // Reset in the middle of a load blanks everything at once.
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_last = 1'b0; wr_char = 5'(i + 3);
            cyc();
        end
        chk("t5_midload_busy", {7'b0, busy}, 8'h01);
        do_reset();

        // Blink request.
        set_scroll(1'b0); run = 1'b1;
        for (int i = 0; i < 6; i++) msg[i] = 10 + i;
        load_msg(6, 1'b0, 1'b1);
        blink = 1'b1;
`ifdef HEX_BLINK_EN
        repeat (124) tick();
        chk_frame("t6_on");
        tick();
        chk_blank("t6_off");
        repeat (124) tick();
        chk_blank("t6_off_end");
        tick();
        chk_frame("t6_on_again");
`else
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_frame("t6_steady");
        end
`endif
        blink = 1'b0;
        repeat (2) cyc();
        chk_frame("t6_blink_off");

        // Randomized messages, modes and tick counts.
        for (int r = 0; r < 12; r++) begin
            set_scroll(1'($urandom_range(0, 1)));
            run = 1'b1;
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) msg[i] = $urandom_range(0, 31);
            load_msg(n, 1'b1, 1'b1);
            chk("rnd_ovf", {7'b0, overflow}, {7'b0, m_ovf});
            nt = $urandom_range(0, 12);
            for (int t = 0; t < nt; t++) begin
                tick();
                chk_frame("rnd_tick");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
